// File: rtl/clk_gate_ctrl.sv
// Registered enable generator for the UART TX/RX clock-gating cell, with idle hold-off,
// wake settle and a 4-phase wake handshake. Define CLK_GATE_STATS_EN to count gate-off events.
module clk_gate_ctrl #(
  parameter int unsigned IDLE_CYCLES = 16,
  parameter int unsigned WAKE_CYCLES = 2,
  parameter int unsigned CNT_W       = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        busy_i,
  input  logic        wake_req,
  input  logic        force_on,
  output logic        CLK_EN,
  output logic        wake_ack,
  output logic        gated,
  output logic [15:0] gate_count
);

  typedef enum logic [1:0] {
    ST_ON,
    ST_COUNTDOWN,
    ST_OFF,
    ST_WAKE
  } state_e;

  localparam logic [CNT_W-1:0] IdleLoad = CNT_W'(IDLE_CYCLES - 1);
  localparam logic [CNT_W-1:0] WakeLoad = CNT_W'(WAKE_CYCLES - 1);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             clk_en_q, clk_en_d;
  logic             gated_q, gated_d;
  logic             wake_ack_q, wake_ack_d;
  logic             act;
  logic             cnt_zero;

  assign act      = busy_i | wake_req | force_on;
  assign cnt_zero = (cnt_q == '0);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_ON;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // The counter only ever decrements from a non-zero value, so it saturates at zero.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      ST_ON: begin
        if (!act) begin
          state_d = ST_COUNTDOWN;
          cnt_d   = IdleLoad;
        end
      end
      ST_COUNTDOWN: begin
        if (act) begin
          state_d = ST_ON;
          cnt_d   = '0;
        end else if (cnt_zero) begin
          state_d = ST_OFF;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      ST_OFF: begin
        if (act) begin
          state_d = ST_WAKE;
          cnt_d   = WakeLoad;
        end
      end
      ST_WAKE: begin
        if (cnt_zero) begin
          state_d = ST_ON;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      default: begin
        state_d = ST_ON;
        cnt_d   = '0;
      end
    endcase
  end

  // Enable/status are decoded from the next state and then registered, so they
  // change on the same edge as the transition yet leave the chip only from flops.
  always_comb begin
    clk_en_d   = (state_d != ST_OFF);
    gated_d    = (state_d == ST_OFF);
    wake_ack_d = wake_req & ((state_q == ST_ON) | (state_q == ST_COUNTDOWN));
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      clk_en_q   <= 1'b1;
      gated_q    <= 1'b0;
      wake_ack_q <= 1'b0;
    end else begin
      clk_en_q   <= clk_en_d;
      gated_q    <= gated_d;
      wake_ack_q <= wake_ack_d;
    end
  end

  assign CLK_EN   = clk_en_q;
  assign gated    = gated_q;
  assign wake_ack = wake_ack_q;

`ifdef CLK_GATE_STATS_EN
  logic        gate_off_evt;
  logic [15:0] gate_count_q, gate_count_d;

  assign gate_off_evt = (state_q == ST_COUNTDOWN) & (state_d == ST_OFF);

  always_comb begin
    gate_count_d = gate_count_q;
    if (gate_off_evt && (gate_count_q != '1)) begin
      gate_count_d = gate_count_q + 16'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      gate_count_q <= '0;
    end else begin
      gate_count_q <= gate_count_d;
    end
  end

  assign gate_count = gate_count_q;
`else
  assign gate_count = '0;
`endif

endmodule

// File: tb/tb_clk_gate_ctrl.sv
// Self-checking bench for clk_gate_ctrl: directed scenarios plus randomized traffic,
// compared every cycle against an idle-run/settle-timer reference model.
module tb_clk_gate_ctrl;

  localparam int unsigned IDLE = 4;
  localparam int unsigned WAKE = 2;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        busy_i = 1'b0;
  logic        wake_req = 1'b0;
  logic        force_on = 1'b0;
  logic        CLK_EN;
  logic        wake_ack;
  logic        gated;
  logic [15:0] gate_count;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  clk_gate_ctrl #(
    .IDLE_CYCLES(IDLE),
    .WAKE_CYCLES(WAKE),
    .CNT_W      (8)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .busy_i    (busy_i),
    .wake_req  (wake_req),
    .force_on  (force_on),
    .CLK_EN    (CLK_EN),
    .wake_ack  (wake_ack),
    .gated     (gated),
    .gate_count(gate_count)
  );

  function automatic void chk(string name, logic [15:0] actual, logic [15:0] expected);
    n_checks++;
    if (actual !== expected) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at t=%0t", name, actual, expected, $time);
    end
  endfunction

  // Reference model: the clock is off once act has been low for IDLE+1 straight edges
  // while running; a wake keeps the domain "not yet on" for WAKE further edges.
  bit m_valid = 1'b0;
  bit m_gated = 1'b0;
  bit m_ack   = 1'b0;
  int m_idle  = 0;
  int m_wake  = 0;
  int m_gcnt  = 0;

  always @(posedge clk) begin
    if (rst) begin
      m_valid = 1'b1;
      m_gated = 1'b0;
      m_ack   = 1'b0;
      m_idle  = 0;
      m_wake  = 0;
      m_gcnt  = 0;
    end else if (m_valid) begin
      m_ack = wake_req && !m_gated && (m_wake == 0);
      if (m_wake > 0) begin
        m_wake--;
      end else if (m_gated) begin
        if (busy_i || wake_req || force_on) begin
          m_gated = 1'b0;
          m_wake  = WAKE;
        end
      end else if (busy_i || wake_req || force_on) begin
        m_idle = 0;
      end else if (m_idle == IDLE) begin
        m_gated = 1'b1;
        m_idle  = 0;
        if (m_gcnt < 65535) m_gcnt++;
      end else begin
        m_idle++;
      end
    end
  end

  function automatic logic [15:0] exp_gcnt();
`ifdef CLK_GATE_STATS_EN
    return 16'(m_gcnt);
`else
    return 16'h0000;
`endif
  endfunction

  always @(negedge clk) begin
    if (m_valid) begin
      chk("model_CLK_EN", 16'(CLK_EN), 16'(!m_gated));
      chk("model_gated", 16'(gated), 16'(m_gated));
      chk("model_wake_ack", 16'(wake_ack), 16'(m_ack));
      chk("model_gate_count", gate_count, exp_gcnt());
    end
  end

  initial begin
    int low;
    int t;

    rst = 1'b1;
    repeat (2) @(negedge clk);
    chk("rst_CLK_EN", 16'(CLK_EN), 16'd1);
    chk("rst_gated", 16'(gated), 16'd0);
    chk("rst_wake_ack", 16'(wake_ack), 16'd0);
    chk("rst_gate_count", gate_count, 16'd0);

    // Idle hold-off: enable must survive four idle edges and fall on the fifth.
    rst = 1'b0;
    for (int i = 1; i <= 4; i++) begin
      @(negedge clk);
      chk("idle_hold_en", 16'(CLK_EN), 16'd1);
      chk("idle_hold_ack", 16'(wake_ack), 16'd0);
    end
    @(negedge clk);
    chk("idle_off_en", 16'(CLK_EN), 16'd0);
    chk("idle_off_gated", 16'(gated), 16'd1);
    chk("model_pin_gated", 16'(m_gated), 16'd1);

    // Wake from OFF: enable next edge, acknowledge on edge 4.
    wake_req = 1'b1;
    @(negedge clk);
    chk("wake_e1_en", 16'(CLK_EN), 16'd1);
    chk("wake_e1_gated", 16'(gated), 16'd0);
    chk("wake_e1_ack", 16'(wake_ack), 16'd0);
    for (int i = 2; i <= 3; i++) begin
      @(negedge clk);
      chk("wake_settle_ack", 16'(wake_ack), 16'd0);
    end
    @(negedge clk);
    chk("wake_e4_ack", 16'(wake_ack), 16'd1);
    chk("model_pin_ack", 16'(m_ack), 16'd1);
    wake_req = 1'b0;
    @(negedge clk);
    chk("ack_fall", 16'(wake_ack), 16'd0);

    // Countdown now at 3; two more idle edges reach counter 1, then a busy pulse.
    repeat (2) @(negedge clk);
    busy_i = 1'b1;
    @(negedge clk);
    busy_i = 1'b0;
    chk("busy_abort_en", 16'(CLK_EN), 16'd1);
    for (int i = 1; i <= 4; i++) begin
      @(negedge clk);
      chk("restart_hold_en", 16'(CLK_EN), 16'd1);
    end
    @(negedge clk);
    chk("restart_off_en", 16'(CLK_EN), 16'd0);

    // force_on keeps the clock running regardless of the other inputs.
    force_on = 1'b1;
    low = 0;
    repeat (100) begin
      @(negedge clk);
      if (!CLK_EN || gated) low++;
    end
    chk("force_on_never_gated", 16'(low), 16'd0);
    force_on = 1'b0;

    // Reset while in WAKE with counter 1.
    repeat (5) @(negedge clk);
    chk("pre_wake_gated", 16'(gated), 16'd1);
    wake_req = 1'b1;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("rst_wake_en", 16'(CLK_EN), 16'd1);
    chk("rst_wake_gated", 16'(gated), 16'd0);
    chk("rst_wake_ack", 16'(wake_ack), 16'd0);
    rst = 1'b0;
    wake_req = 1'b0;
    for (int i = 1; i <= 4; i++) begin
      @(negedge clk);
      chk("post_rst_hold_en", 16'(CLK_EN), 16'd1);
    end
    @(negedge clk);
    chk("post_rst_off_en", 16'(CLK_EN), 16'd0);

    // Reset while OFF.
    rst = 1'b1;
    @(negedge clk);
    chk("rst_off_en", 16'(CLK_EN), 16'd1);
    chk("rst_off_gated", 16'(gated), 16'd0);
    chk("rst_off_ack", 16'(wake_ack), 16'd0);
    rst = 1'b0;

    // Three full idle -> OFF -> wake cycles for the gate-off statistic.
    for (int k = 0; k < 3; k++) begin
      repeat (5) @(negedge clk);
      chk("stats_off_gated", 16'(gated), 16'd1);
      wake_req = 1'b1;
      t = 0;
      while (!wake_ack && t < 20) begin
        @(negedge clk);
        t++;
      end
      chk("stats_ack_in_time", 16'(t < 20), 16'd1);
      wake_req = 1'b0;
    end
    @(negedge clk);
`ifdef CLK_GATE_STATS_EN
    chk("gate_count_3", gate_count, 16'd3);
`else
    chk("gate_count_tied", gate_count, 16'd0);
`endif

    // Randomized traffic; wake_req follows the 4-phase rule.
    for (int c = 0; c < 4000; c++) begin
      @(negedge clk);
      rst    = ($urandom_range(0, 299) == 0);
      busy_i = ($urandom_range(0, 99) < 12);
      if ($urandom_range(0, 199) == 0) force_on = ~force_on;
      if (!wake_req) wake_req = ($urandom_range(0, 39) == 0);
      else if (wake_ack) wake_req = ($urandom_range(0, 2) == 0);
    end
    @(negedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
